// File: rtl/pixel_array_adc.sv
// pixel_array_adc: integrating pixel array sharing one single-slope ramp ADC,
// with the latched codes handed out over a valid/ready stream.
module pixel_array_adc #(
  parameter int N_PIXELS      = 4,
  parameter int WIDTH         = 8,
  parameter int EXPOSE_CYCLES = 8,
  localparam int IW           = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [N_PIXELS*WIDTH-1:0] light,
  output logic [WIDTH-1:0]          out_data,
  output logic [IW-1:0]             out_index,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      frame_done
);

  // state   | meaning
  // IDLE    | waiting for start
  // ERASE   | pixels charged to full scale, comparators and counters cleared
  // EXPOSE  | photo level integrated down for EXPOSE_CYCLES cycles
  // CONVERT | ramp sweeps 0..2^WIDTH-1 once, comparators latch the ramp code
  // READOUT | latched codes presented one per valid/ready handshake
  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READOUT
  } state_t;

  localparam logic [WIDTH-1:0] FULL_SCALE = '1;

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    acc   [N_PIXELS];
  logic [WIDTH-1:0]    latch [N_PIXELS];
  logic [N_PIXELS-1:0] cmp;
  logic [7:0]          exp_cnt;
  logic [WIDTH-1:0]    ramp;
  logic [IW-1:0]       k;
  logic                done_q;
  logic                exp_tc;
  logic                ramp_tc;
  logic                k_last;
  logic                hs;

  assign exp_tc  = (exp_cnt == 8'(EXPOSE_CYCLES - 1));
  assign ramp_tc = (ramp == FULL_SCALE);
  assign k_last  = (k == IW'(N_PIXELS - 1));
  assign hs      = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_ERASE;
      S_ERASE:   state_nxt = S_EXPOSE;
      S_EXPOSE:  if (exp_tc) state_nxt = S_CONVERT;
      S_CONVERT: if (ramp_tc) state_nxt = S_READOUT;
      S_READOUT: if (hs && k_last) state_nxt = continuous ? S_ERASE : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_PIXELS; i++) begin
        acc[i]   <= '0;
        latch[i] <= '0;
      end
      cmp     <= '0;
      exp_cnt <= '0;
      ramp    <= '0;
      k       <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_ERASE: begin
          for (int i = 0; i < N_PIXELS; i++) begin
            acc[i]   <= FULL_SCALE;
            latch[i] <= '0;
          end
          cmp     <= '0;
          exp_cnt <= '0;
          ramp    <= '0;
          k       <= '0;
        end
        S_EXPOSE: begin
          // Saturate at zero: a bright pixel must read 0, never wrap to a dark code.
          for (int i = 0; i < N_PIXELS; i++) begin
            acc[i] <= (acc[i] > light[i*WIDTH +: WIDTH]) ?
                      acc[i] - light[i*WIDTH +: WIDTH] : '0;
          end
          exp_cnt <= exp_cnt + 8'd1;
        end
        S_CONVERT: begin
          for (int i = 0; i < N_PIXELS; i++) begin
            if (!cmp[i]) latch[i] <= ramp;
            if (ramp >= acc[i]) cmp[i] <= 1'b1;
          end
          if (!ramp_tc) ramp <= ramp + WIDTH'(1);
        end
        S_READOUT: begin
          if (hs) begin
            if (k_last) begin
              k      <= '0;
              done_q <= 1'b1;
            end else begin
              k <= k + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid  = (state == S_READOUT);
  assign out_data   = out_valid ? latch[k] : '0;
  assign out_index  = out_valid ? k : '0;
  assign busy       = (state != S_IDLE);
  assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_array_adc.sv
// Scoreboard bench for pixel_array_adc: expected codes come from the exposure
// arithmetic; a negedge monitor pops and compares every accepted word.
`timescale 1ns/1ps
module tb_pixel_array_adc;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int E    = 8;
  localparam int IW   = 2;
  localparam int MAXC = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           continuous;
  logic [N*W-1:0] light;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_index;
  logic           out_valid;
  logic           out_ready;
  logic           busy;
  logic           frame_done;

  pixel_array_adc #(.N_PIXELS(N), .WIDTH(W), .EXPOSE_CYCLES(E)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .continuous (continuous),
    .light      (light),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int data;
  } word_t;

  word_t       sb[$];
  int          vectors      = 0;
  int          miscompares  = 0;
  int          fd_count     = 0;
  bit          rand_ready   = 1'b0;
  bit          hold_pending = 1'b0;
  int          hold_data    = 0;
  int          hold_idx     = 0;
  bit          prev_last_hs = 1'b0;
  bit          last_fd_busy = 1'b0;
  int unsigned lv[N];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Full-scale charge minus the integrated photo level, clipped at zero.
  function automatic int model(input int unsigned l);
    int v;
    v = MAXC - E * int'(l);
    return (v < 0) ? 0 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic load_expect();
    for (int i = 0; i < N; i++) begin
      light[i*W +: W] = W'(lv[i]);
      sb.push_back('{idx: i, data: model(lv[i])});
    end
  endtask

  task automatic wait_fd(input int target);
    int n;
    n = 0;
    while (fd_count < target && n < 3000) begin
      tick();
      n++;
    end
    if (fd_count < target) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_done_timeout: got %0d frames, expected %0d", fd_count, target);
    end
  endtask

  always @(negedge clk) begin
    word_t w;
    if (reset) begin
      hold_pending = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      if (frame_done || prev_last_hs)
        check("frame_done_pulse", int'(frame_done), int'(prev_last_hs));
      if (frame_done) begin
        fd_count++;
        last_fd_busy = busy;
      end
      if (hold_pending) begin
        check("hold_valid", int'(out_valid), 1);
        if (out_valid) begin
          check("hold_index", int'(out_index), hold_idx);
          check("hold_data", int'(out_data), hold_data);
        end
      end
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_word: got index %0d data %0d, expected no word",
                     out_index, out_data);
          end else begin
            w = sb.pop_front();
            check("word_index", int'(out_index), w.idx);
            check("word_data", int'(out_data), w.data);
          end
        end
      end else begin
        check("idle_data", int'(out_data), 0);
        check("idle_index", int'(out_index), 0);
      end
      hold_pending = out_valid && !out_ready;
      hold_data    = int'(out_data);
      hold_idx     = int'(out_index);
      prev_last_hs = out_valid && out_ready && (out_index == IW'(N - 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int t;
    reset      = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
    light      = '0;
    out_ready  = 1'b1;
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_index", int'(out_index), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reference frame with latency measurement.
    lv = '{0, 1, 10, 40};
    load_expect();
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 2000) begin
      tick();
      cycles++;
    end
    check("first_valid_latency", cycles, 1 + E + (1 << W));
    wait_fd(1);
    tick();
    check("busy_after_frame", int'(busy), 0);

    // Backpressure on pixel 1 for five cycles.
    load_expect();
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 2000) begin
      tick();
      cycles++;
    end
    tick();
    check("stall_index", int'(out_index), 1);
    check("stall_data", int'(out_data), 247);
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      check("stall_valid", int'(out_valid), 1);
      check("stall_index", int'(out_index), 1);
      check("stall_data", int'(out_data), 247);
    end
    out_ready = 1'b1;
    wait_fd(2);

    // Random light levels with random backpressure.
    rand_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++)
        lv[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 35);
      load_expect();
      t = fd_count + 1;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_fd(t);
      repeat (3) tick();
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    tick();

    // Reset in the middle of CONVERT aborts the frame silently.
    for (int i = 0; i < N; i++) lv[i] = $urandom_range(0, 30);
    for (int i = 0; i < N; i++) light[i*W +: W] = W'(lv[i]);
    t = fd_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (1 + E + 100) tick();
    check("busy_in_convert", int'(busy), 1);
    #1 reset = 1'b1;
    #1;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_data", int'(out_data), 0);
    check("midrst_index", int'(out_index), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_frame_done", int'(frame_done), 0);
    tick();
    tick();
    reset = 1'b0;
    repeat (300) tick();
    check("aborted_no_frame_done", fd_count, t);
    load_expect();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_fd(t + 1);

    // Start held high through ERASE/EXPOSE gives exactly one frame.
    for (int i = 0; i < N; i++) lv[i] = $urandom_range(0, 40);
    load_expect();
    t = fd_count + 1;
    start = 1'b1;
    repeat (6) tick();
    start = 1'b0;
    wait_fd(t);
    repeat (300) tick();
    check("single_frame_count", fd_count, t);

    // Continuous mode: three back-to-back frames of constant light.
    lv = '{2, 2, 2, 2};
    load_expect();
    load_expect();
    load_expect();
    continuous = 1'b1;
    t = fd_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_fd(t + 1);
    check("cont_busy_at_done1", int'(last_fd_busy), 1);
    wait_fd(t + 2);
    check("cont_busy_at_done2", int'(last_fd_busy), 1);
    continuous = 1'b0;
    wait_fd(t + 3);
    repeat (300) tick();
    check("cont_frame_count", fd_count, t + 3);
    check("cont_busy_after", int'(busy), 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
